// File: rtl/gb_cpu_irq_ctrl_pkg.sv
// Shared types and helpers for the CPU interrupt controller.
//   irq_state_t   : dispatch FSM states
//   irq_reg_sel_t : register select encoding for CPU writes (IF / IE)
//   DMG_NUM_IRQ   : number of interrupt sources on the original DMG
//   irq_vector()  : vector address of a source, wrapped to 16 bits
package gb_cpu_irq_ctrl_pkg;

    typedef enum logic [1:0] {IRQ_IDLE, IRQ_REQ, IRQ_ACK} irq_state_t;

    typedef enum logic {IRQ_SEL_IF, IRQ_SEL_IE} irq_reg_sel_t;

    localparam int unsigned DMG_NUM_IRQ = 5;

    function automatic logic [15:0] irq_vector(input logic [15:0] base,
                                               input int unsigned stride,
                                               input int unsigned id);
        return 16'(32'(base) + stride * id);
    endfunction

endpackage

// File: rtl/gb_cpu_irq_ctrl_if.sv
// Bus between the CPU core / peripherals and the interrupt controller.
//   master : CPU-side view (drives requests, strobes, ack; observes status)
//   slave  : controller-side view
interface gb_cpu_irq_ctrl_if #(
    parameter int unsigned NUM_IRQ = 5
);
    localparam int unsigned ID_W = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;

    logic [NUM_IRQ-1:0] irq_i;
    logic               reg_wr_en;
    logic               reg_sel;
    logic [NUM_IRQ-1:0] reg_wdata;
    logic [NUM_IRQ-1:0] if_o;
    logic [NUM_IRQ-1:0] ie_o;
    logic               instr_done_i;
    logic               ei_i;
    logic               di_i;
    logic               reti_i;
    logic               halt_i;
    logic               ime_o;
    logic               irq_req_o;
    logic               ack_i;
    logic [15:0]        vector_o;
    logic [ID_W-1:0]    irq_id_o;
    logic               halted_o;
    logic               halt_bug_o;

    modport master (
        output irq_i, reg_wr_en, reg_sel, reg_wdata, instr_done_i,
               ei_i, di_i, reti_i, halt_i, ack_i,
        input  if_o, ie_o, ime_o, irq_req_o, vector_o, irq_id_o,
               halted_o, halt_bug_o
    );

    modport slave (
        input  irq_i, reg_wr_en, reg_sel, reg_wdata, instr_done_i,
               ei_i, di_i, reti_i, halt_i, ack_i,
        output if_o, ie_o, ime_o, irq_req_o, vector_o, irq_id_o,
               halted_o, halt_bug_o
    );

endinterface

// File: rtl/gb_cpu_irq_prio_enc.sv
// Combinational lowest-set-bit priority encoder.
//   req_i   : request vector, bit 0 = highest priority
//   valid_o : any request set
//   index_o : index of the lowest set bit (0 when none)
module gb_cpu_irq_prio_enc #(
    parameter int unsigned N = 5,
    parameter int unsigned W = 3
) (
    input  logic [N-1:0] req_i,
    output logic         valid_o,
    output logic [W-1:0] index_o
);

    always_comb begin
        logic found;
        found   = 1'b0;
        index_o = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (req_i[i] && !found) begin
                found   = 1'b1;
                index_o = W'(i);
            end
        end
        valid_o = found;
    end

endmodule

// File: rtl/gb_cpu_irq_ctrl.sv
// Interrupt controller between peripherals and the CPU core.
// Owns IF/IE, latches peripheral requests (edge or level per source),
// manages IME with a delayed EI, prioritises pending sources, runs the
// request/ack dispatch handshake and produces HALT wake / HALT-bug signals.
//   clk   : M-cycle clock
//   reset : asynchronous active-low reset
//   bus   : controller side of gb_cpu_irq_ctrl_if (requests, register
//           access, instruction strobes, dispatch handshake, status)
module gb_cpu_irq_ctrl
    import gb_cpu_irq_ctrl_pkg::*;
#(
    parameter int unsigned        NUM_IRQ       = DMG_NUM_IRQ,
    parameter logic [15:0]        VECTOR_BASE   = 16'h0040,
    parameter int unsigned        VECTOR_STRIDE = 8,
    parameter int unsigned        EI_DELAY      = 1,
    parameter logic [NUM_IRQ-1:0] EDGE_MASK     = '1
) (
    input logic              clk,
    input logic              reset,
    gb_cpu_irq_ctrl_if.slave bus
);

    localparam int unsigned ID_W = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;

    logic [NUM_IRQ-1:0] if_q, if_d;
    logic [NUM_IRQ-1:0] ie_q, ie_d;
    logic [NUM_IRQ-1:0] irq_prev_q;
    logic [NUM_IRQ-1:0] pend;
    logic [NUM_IRQ-1:0] hw_set;
    logic               ime_q, ime_d;
    logic [2:0]         ei_cnt_q, ei_cnt_d;
    irq_state_t         state_q, state_d;
    logic               halted_q, halted_d;
    logic               halt_bug_q, halt_bug_d;
    logic               pend_any;
    logic [ID_W-1:0]    win_id;
    logic               ack_fire;
    logic               in_req;

    assign pend     = if_q & ie_q;
    assign in_req   = (state_q == IRQ_REQ);
    assign ack_fire = in_req && bus.ack_i;

    // Edge sources set on a 0->1 transition, level sources while high.
    assign hw_set = (EDGE_MASK & bus.irq_i & ~irq_prev_q) | (~EDGE_MASK & bus.irq_i);

    gb_cpu_irq_prio_enc #(
        .N (NUM_IRQ),
        .W (ID_W)
    ) u_prio (
        .req_i   (pend),
        .valid_o (pend_any),
        .index_o (win_id)
    );

    // IF: write < ack clear < hardware set (set always wins on a collision).
    always_comb begin
        if_d = if_q;
        if (bus.reg_wr_en && irq_reg_sel_t'(bus.reg_sel) == IRQ_SEL_IF) begin
            if_d = bus.reg_wdata;
        end
        if (ack_fire && pend_any) begin
            if_d[win_id] = 1'b0;
        end
        if_d = if_d | hw_set;
    end

    always_comb begin
        ie_d = ie_q;
        if (bus.reg_wr_en && irq_reg_sel_t'(bus.reg_sel) == IRQ_SEL_IE) begin
            ie_d = bus.reg_wdata;
        end
    end

    // IME: later statements take precedence (ack > di > reti > ei > countdown).
    always_comb begin
        ime_d    = ime_q;
        ei_cnt_d = ei_cnt_q;
        if (ei_cnt_q != 3'd0 && bus.instr_done_i) begin
            ei_cnt_d = ei_cnt_q - 3'd1;
            if (ei_cnt_q == 3'd1) begin
                ime_d = 1'b1;
            end
        end
        if (bus.ei_i) begin
            ei_cnt_d = 3'(EI_DELAY);
        end
        if (bus.reti_i) begin
            ime_d    = 1'b1;
            ei_cnt_d = 3'd0;
        end
        if (bus.di_i) begin
            ime_d    = 1'b0;
            ei_cnt_d = 3'd0;
        end
        if (ack_fire) begin
            ime_d    = 1'b0;
            ei_cnt_d = 3'd0;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IRQ_IDLE: if (bus.instr_done_i && ime_q && pend_any) state_d = IRQ_REQ;
            IRQ_REQ:  if (bus.ack_i) state_d = IRQ_ACK;
            IRQ_ACK:  state_d = IRQ_IDLE;
            default:  state_d = IRQ_IDLE;
        endcase
    end

    always_comb begin
        halted_d   = halted_q;
        halt_bug_d = 1'b0;
        if (halted_q && pend_any) begin
            halted_d = 1'b0;
        end
        if (bus.halt_i) begin
            if (!pend_any) begin
                halted_d = 1'b1;
            end else if (!ime_q) begin
                halt_bug_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            if_q       <= '0;
            ie_q       <= '0;
            irq_prev_q <= '0;
            ime_q      <= 1'b0;
            ei_cnt_q   <= 3'd0;
            state_q    <= IRQ_IDLE;
            halted_q   <= 1'b0;
            halt_bug_q <= 1'b0;
        end else begin
            if_q       <= if_d;
            ie_q       <= ie_d;
            irq_prev_q <= bus.irq_i;
            ime_q      <= ime_d;
            ei_cnt_q   <= ei_cnt_d;
            state_q    <= state_d;
            halted_q   <= halted_d;
            halt_bug_q <= halt_bug_d;
        end
    end

    // Id and vector follow the live winner so a higher-priority arrival
    // preempts before ack; a fully cancelled request presents vector 0.
    assign bus.if_o       = if_q;
    assign bus.ie_o       = ie_q;
    assign bus.ime_o      = ime_q;
    assign bus.irq_req_o  = in_req;
    assign bus.irq_id_o   = in_req ? win_id : '0;
    assign bus.vector_o   = (in_req && pend_any)
                          ? irq_vector(VECTOR_BASE, VECTOR_STRIDE, 32'(win_id))
                          : 16'h0000;
    assign bus.halted_o   = halted_q;
    assign bus.halt_bug_o = halt_bug_q;

endmodule

// File: tb/tb_gb_cpu_irq_ctrl.sv
module tb_gb_cpu_irq_ctrl;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    gb_cpu_irq_ctrl_if #(.NUM_IRQ(5)) busA ();
    gb_cpu_irq_ctrl_if #(.NUM_IRQ(8)) busB ();

    gb_cpu_irq_ctrl #(
        .NUM_IRQ       (5),
        .VECTOR_BASE   (16'h0040),
        .VECTOR_STRIDE (8),
        .EI_DELAY      (1),
        .EDGE_MASK     (5'h1F)
    ) dutA (
        .clk   (clk),
        .reset (reset),
        .bus   (busA)
    );

    gb_cpu_irq_ctrl #(
        .NUM_IRQ       (8),
        .VECTOR_BASE   (16'hFFF8),
        .VECTOR_STRIDE (4),
        .EI_DELAY      (1),
        .EDGE_MASK     (8'hFF)
    ) dutB (
        .clk   (clk),
        .reset (reset),
        .bus   (busB)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_a();
        busA.irq_i = '0; busA.reg_wr_en = 0; busA.reg_sel = 0; busA.reg_wdata = '0;
        busA.instr_done_i = 0; busA.ei_i = 0; busA.di_i = 0; busA.reti_i = 0;
        busA.halt_i = 0; busA.ack_i = 0;
    endtask

    task automatic clear_b();
        busB.irq_i = '0; busB.reg_wr_en = 0; busB.reg_sel = 0; busB.reg_wdata = '0;
        busB.instr_done_i = 0; busB.ei_i = 0; busB.di_i = 0; busB.reti_i = 0;
        busB.halt_i = 0; busB.ack_i = 0;
    endtask

    initial begin
        clear_a();
        clear_b();
        #12;
        chk("rst_if", 32'(busA.if_o), 32'h0);
        chk("rst_ie", 32'(busA.ie_o), 32'h0);
        chk("rst_ime", 32'(busA.ime_o), 32'h0);
        chk("rst_req", 32'(busA.irq_req_o), 32'h0);
        chk("rst_vec", 32'(busA.vector_o), 32'h0);
        chk("rst_halted", 32'(busA.halted_o), 32'h0);
        reset = 1'b1;
        tick();

        // 1. priority
        busA.reg_wr_en = 1; busA.reg_sel = 1; busA.reg_wdata = 5'h1F; tick(); clear_a();
        chk("ie_write", 32'(busA.ie_o), 32'h1F);
        busA.irq_i = 5'h10; tick(); clear_a();
        busA.irq_i = 5'h02; tick(); clear_a();
        chk("if_latch", 32'(busA.if_o), 32'h12);
        busA.reti_i = 1; tick(); clear_a();
        chk("reti_ime", 32'(busA.ime_o), 32'h1);
        busA.instr_done_i = 1; tick(); clear_a();
        chk("p_req", 32'(busA.irq_req_o), 32'h1);
        chk("p_vec", 32'(busA.vector_o), 32'h0048);
        chk("p_id", 32'(busA.irq_id_o), 32'h1);
        busA.ack_i = 1; tick(); clear_a();
        chk("p_if_after_ack", 32'(busA.if_o), 32'h10);
        chk("p_req_ack", 32'(busA.irq_req_o), 32'h0);
        chk("p_ime_ack", 32'(busA.ime_o), 32'h0);
        tick();
        busA.reti_i = 1; tick(); clear_a();
        busA.instr_done_i = 1; tick(); clear_a();
        chk("p2_vec", 32'(busA.vector_o), 32'h0060);
        chk("p2_id", 32'(busA.irq_id_o), 32'h4);
        busA.ack_i = 1; tick(); clear_a();
        chk("p2_if", 32'(busA.if_o), 32'h0);
        tick();

        // 2. EI delay
        busA.ei_i = 1; tick(); clear_a();
        chk("ei_wait", 32'(busA.ime_o), 32'h0);
        busA.instr_done_i = 1; tick(); clear_a();
        chk("ei_set", 32'(busA.ime_o), 32'h1);
        busA.di_i = 1; tick(); clear_a();
        chk("di_clr", 32'(busA.ime_o), 32'h0);
        busA.ei_i = 1; tick(); clear_a();
        busA.di_i = 1; tick(); clear_a();
        busA.instr_done_i = 1; tick(); clear_a();
        chk("ei_cancel", 32'(busA.ime_o), 32'h0);
        busA.ei_i = 1; busA.di_i = 1; tick(); clear_a();
        busA.instr_done_i = 1; tick(); clear_a();
        chk("ei_di_same", 32'(busA.ime_o), 32'h0);

        // 3. cancel in REQ
        busA.irq_i = 5'h01; tick(); clear_a();
        busA.reti_i = 1; tick(); clear_a();
        busA.instr_done_i = 1; tick(); clear_a();
        chk("c_vec0", 32'(busA.vector_o), 32'h0040);
        busA.reg_wr_en = 1; busA.reg_sel = 0; busA.reg_wdata = '0; tick(); clear_a();
        chk("c_vec_cancel", 32'(busA.vector_o), 32'h0000);
        chk("c_req_hold", 32'(busA.irq_req_o), 32'h1);
        busA.ack_i = 1; tick(); clear_a();
        chk("c_if", 32'(busA.if_o), 32'h0);
        chk("c_ime", 32'(busA.ime_o), 32'h0);
        tick();

        // 4. ack / edge collision on id 2
        busA.irq_i = 5'h04; tick(); clear_a();
        busA.reti_i = 1; tick(); clear_a();
        busA.instr_done_i = 1; tick(); clear_a();
        chk("col_vec", 32'(busA.vector_o), 32'h0050);
        busA.ack_i = 1; busA.irq_i = 5'h04; tick(); clear_a();
        chk("col_if", 32'(busA.if_o), 32'h04);
        chk("col_ime", 32'(busA.ime_o), 32'h0);
        tick();
        busA.reg_wr_en = 1; busA.reg_sel = 0; busA.reg_wdata = '0; tick(); clear_a();

        // 5. HALT
        busA.reg_wr_en = 1; busA.reg_sel = 1; busA.reg_wdata = 5'h04; tick(); clear_a();
        busA.halt_i = 1; tick(); clear_a();
        chk("h_halted", 32'(busA.halted_o), 32'h1);
        busA.irq_i = 5'h04; tick(); clear_a();
        chk("h_still", 32'(busA.halted_o), 32'h1);
        tick();
        chk("h_wake", 32'(busA.halted_o), 32'h0);
        chk("h_noreq", 32'(busA.irq_req_o), 32'h0);
        busA.halt_i = 1; tick(); clear_a();
        chk("hb_pulse", 32'(busA.halt_bug_o), 32'h1);
        chk("hb_nohalt", 32'(busA.halted_o), 32'h0);
        tick();
        chk("hb_single", 32'(busA.halt_bug_o), 32'h0);

        // 6. wrapped vector on the 8-source instance, then async reset in REQ
        busB.reg_wr_en = 1; busB.reg_sel = 1; busB.reg_wdata = 8'h08; tick(); clear_b();
        busB.reti_i = 1; busB.irq_i = 8'h08; tick(); clear_b();
        busB.instr_done_i = 1; tick(); clear_b();
        chk("w_req", 32'(busB.irq_req_o), 32'h1);
        chk("w_vec", 32'(busB.vector_o), 32'h0004);
        chk("w_id", 32'(busB.irq_id_o), 32'h3);
        #2 reset = 1'b0;
        #1;
        chk("ar_req", 32'(busB.irq_req_o), 32'h0);
        chk("ar_vec", 32'(busB.vector_o), 32'h0);
        chk("ar_if", 32'(busB.if_o), 32'h0);
        chk("ar_ie", 32'(busB.ie_o), 32'h0);
        chk("ar_ime", 32'(busB.ime_o), 32'h0);
        chk("ar_a_if", 32'(busA.if_o), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
